piso_reader: RTL



---
 rtl/piso_reader_pkg.sv | 23 ++
 rtl/piso_reader_if.sv | 36 +++
 rtl/piso_reader_sync2.sv | 22 ++
 rtl/piso_reader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/piso_reader_pkg.sv
// Shared types, defaults and helpers for the 74HC165-style input scanner.
package piso_reader_pkg;

   localparam int DEFAULT_NBITS = 8;
   localparam int DEFAULT_DIV   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOW,
      HIGH,
      DONE
   } state_t;

   // Bits needed to hold a counter that takes the values 0..num_values-1.
   function automatic int cnt_width(input int num_values);
      if (num_values <= 2) begin
         return 1;
      end
      return $clog2(num_values);
   endfunction

endpackage

// File: rtl/piso_reader_if.sv
// Bundle of the scanner's fabric handshake and the external shift-register pins.
interface piso_reader_if #(
   parameter int NBITS = piso_reader_pkg::DEFAULT_NBITS
);

   logic             start;
   logic [NBITS-1:0] data;
   logic             valid;
   logic             busy;
   logic             sr_load_n;
   logic             sr_clk;
   logic             sr_din;

   // The scanner itself: drives the '165 control pins and the result word.
   modport master (
      input  start,
      input  sr_din,
      output data,
      output valid,
      output busy,
      output sr_load_n,
      output sr_clk
   );

   // The surroundings: fabric requesting scans and the '165 returning bits.
   modport slave (
      output start,
      output sr_din,
      input  data,
      input  valid,
      input  busy,
      input  sr_load_n,
      input  sr_clk
   );

endinterface

// File: rtl/piso_reader_sync2.sv
// Two-flop synchronizer for a single asynchronous pin, reset to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give the first one a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/piso_reader.sv
// Scanner for an external 74HC165-style PISO register: load, clock out NBITS
// bits MSB-first, and present them as a parallel word with a valid strobe.
module piso_reader
   import piso_reader_pkg::*;
#(
   parameter int NBITS = DEFAULT_NBITS,
   parameter int DIV   = DEFAULT_DIV
) (
   input logic           clk,
   input logic           rst_n,
   piso_reader_if.master bus
);

   localparam int PW = cnt_width(DIV);
   localparam int BW = cnt_width(NBITS + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

   if (DIV < 3) begin : g_div_check
      $error("piso_reader: DIV must be at least 3 so the synchronized bit is settled");
   end
   if (NBITS < 2) begin : g_nbits_check
      $error("piso_reader: NBITS must be at least 2");
   end

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [NBITS-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             load_n_q, load_n_d;
   logic             sr_clk_q, sr_clk_d;
   logic             din_sync;
   logic             phase_end;

   sync2 u_din_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.sr_din),
      .q     (din_sync)
   );

   assign phase_end     = (phase_q == PHASE_LAST);
   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
   assign bus.sr_load_n = load_n_q;
   assign bus.sr_clk    = sr_clk_q;

   // State, counters and every output are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         load_n_q <= 1'b1;
         sr_clk_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         load_n_q <= load_n_d;
         sr_clk_q <= sr_clk_d;
      end
   end

   // Next state and next outputs; the word and strobe land on entry to DONE so
   // valid is visible during DONE, and DONE (already not busy) accepts a new
   // start just like IDLE, which keeps back-to-back scans one cycle apart.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      load_n_d = load_n_q;
      sr_clk_d = sr_clk_q;

      case (state_q)
         IDLE, DONE: begin
            phase_d = '0;
            bit_d   = '0;
            if (bus.start) begin
               state_d  = LOAD;
               load_n_d = 1'b0;
               busy_d   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         LOAD: begin
            if (phase_end) begin
               phase_d  = '0;
               load_n_d = 1'b1;
               state_d  = LOW;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         LOW: begin
            if (phase_end) begin
               phase_d = '0;
               shreg_d = {shreg_q[NBITS-2:0], din_sync};
               bit_d   = bit_q + BW'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = DONE;
                  data_d  = {shreg_q[NBITS-2:0], din_sync};
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  sr_clk_d = 1'b1;
                  state_d  = HIGH;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         HIGH: begin
            if (phase_end) begin
               phase_d  = '0;
               sr_clk_d = 1'b0;
               state_d  = LOW;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
